alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two requesters share one single-cycle ALU: round-robin issue, one result slot per requester.
// Latency: accept T, ALU issue T+1, result T+2, response T+3; response back-pressure stalls only its own requester.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int INST_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_data_a,
  input  logic [DATA_W-1:0] i_req0_data_b,
  input  logic [INST_W-1:0] i_req0_inst,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_data_a,
  input  logic [DATA_W-1:0] i_req1_data_b,
  input  logic [INST_W-1:0] i_req1_inst,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic              o_alu_valid,
  output logic [DATA_W-1:0] o_alu_data_a,
  output logic [DATA_W-1:0] o_alu_data_b,
  output logic [INST_W-1:0] o_alu_inst,
  input  logic              i_alu_valid,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic [CNT_W-1:0]  o_cnt0,
  output logic [CNT_W-1:0]  o_cnt1,
  output logic              o_err
);

  typedef enum logic [1:0] {FREE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HELD = 2'd3} slot_e;

  slot_e             slot   [2];
  logic [DATA_W-1:0] result [2];
  logic [CNT_W-1:0]  cnt    [2];
  logic              tag;
  logic              last_grant;
  logic [1:0]        req_valid, rsp_ready, elig, grant, rsp_valid, rsp_hs;
  logic              any_issue, any_wait, alu_hit, alu_spur;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // Only one command may occupy the issue stage, so nobody is eligible while either slot is in ISSUE.
  assign any_issue = (slot[0] == ISSUE) || (slot[1] == ISSUE);
  assign any_wait  = (slot[0] == WAIT)  || (slot[1] == WAIT);
  assign elig[0]   = ~i_rst & req_valid[0] & (slot[0] == FREE) & ~any_issue;
  assign elig[1]   = ~i_rst & req_valid[1] & (slot[1] == FREE) & ~any_issue;

  // last_grant = 1 means requester 1 won last, so requester 0 takes a tie.
  assign grant[0] = elig[0] & (~elig[1] | last_grant);
  assign grant[1] = elig[1] & (~elig[0] | ~last_grant);

  assign rsp_valid[0] = ~i_rst & (slot[0] == HELD);
  assign rsp_valid[1] = ~i_rst & (slot[1] == HELD);
  assign rsp_hs       = rsp_valid & rsp_ready;

  assign alu_hit  = i_alu_valid & (slot[tag] == WAIT);
  assign alu_spur = i_alu_valid & ~any_wait;

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign o_rsp0_valid = rsp_valid[0];
  assign o_rsp1_valid = rsp_valid[1];
  assign o_rsp0_data  = result[0];
  assign o_rsp1_data  = result[1];
  assign o_cnt0       = cnt[0];
  assign o_cnt1       = cnt[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 2; n++) begin
        slot[n]   <= FREE;
        result[n] <= '0;
        cnt[n]    <= '0;
      end
      tag          <= 1'b0;
      last_grant   <= 1'b1;
      o_alu_valid  <= 1'b0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_inst   <= '0;
      o_err        <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        case (slot[n])
          FREE:  if (grant[n]) slot[n] <= ISSUE;
          ISSUE: slot[n] <= WAIT;
          WAIT: begin
            if (alu_hit && (int'(tag) == n)) begin
              slot[n]   <= HELD;
              result[n] <= i_alu_data;
            end
          end
          HELD: begin
            if (rsp_hs[n]) begin
              slot[n] <= FREE;
              if (cnt[n] != {CNT_W{1'b1}}) cnt[n] <= cnt[n] + CNT_W'(1);
            end
          end
          default: slot[n] <= FREE;
        endcase
      end

      if (|grant) begin
        o_alu_valid  <= 1'b1;
        o_alu_data_a <= grant[1] ? i_req1_data_a : i_req0_data_a;
        o_alu_data_b <= grant[1] ? i_req1_data_b : i_req0_data_b;
        o_alu_inst   <= grant[1] ? i_req1_inst   : i_req0_inst;
        tag          <= grant[1];
        last_grant   <= grant[1];
      end else begin
        o_alu_valid <= 1'b0;
      end

      if (alu_spur) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-driven requesters, a one-cycle ALU model, and a per-cycle transaction-level reference.
module tb_alu_arbiter;
  localparam int DW   = 8;
  localparam int IW   = 3;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [IW-1:0] inst;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic [DW-1:0] i_req0_data_a = '0, i_req0_data_b = '0, i_req1_data_a = '0, i_req1_data_b = '0;
  logic [IW-1:0] i_req0_inst = '0, i_req1_inst = '0;
  logic          i_rsp0_ready = 1'b1, i_rsp1_ready = 1'b1;
  logic          i_alu_valid = 1'b0;
  logic [DW-1:0] i_alu_data = '0;
  logic          o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_alu_valid, o_err;
  logic [DW-1:0] o_rsp0_data, o_rsp1_data, o_alu_data_a, o_alu_data_b;
  logic [IW-1:0] o_alu_inst;
  logic [CW-1:0] o_cnt0, o_cnt1;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .INST_W(IW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_data_a(i_req0_data_a), .i_req0_data_b(i_req0_data_b), .i_req0_inst(i_req0_inst),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_data_a(i_req1_data_a), .i_req1_data_b(i_req1_data_b), .i_req1_inst(i_req1_inst),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready), .o_rsp0_data(o_rsp0_data),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready), .o_rsp1_data(o_rsp1_data),
    .o_alu_valid(o_alu_valid), .o_alu_data_a(o_alu_data_a), .o_alu_data_b(o_alu_data_b),
    .o_alu_inst(o_alu_inst), .i_alu_valid(i_alu_valid), .i_alu_data(i_alu_data),
    .o_cnt0(o_cnt0), .o_cnt1(o_cnt1), .o_err(o_err)
  );

  int   compared = 0, mismatched = 0, cyc = 0;
  cmd_t q0[$], q1[$];
  int   idx0 = 0, idx1 = 0;
  int   spur_set = 0, spur_used = 0;
  bit   alu_en = 1'b1;
  bit   hs0 = 1'b0, hs1 = 1'b0, alu_pend = 1'b0;
  logic [DW-1:0] alu_res = '0;

  // Reference state: per-requester outstanding/held result, issue-stage contents, ALU return order.
  bit            started = 1'b0;
  bit            m_out [2], m_have [2];
  logic [DW-1:0] m_res [2];
  int            m_cnt [2];
  bit            m_err, m_av;
  logic [DW-1:0] m_aa, m_ab;
  logic [IW-1:0] m_ai;
  int            m_atag, m_last;
  int            m_wq[$];

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return b;
    endcase
  endfunction

  function automatic cmd_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] op);
    cmd_t c;
    c.a = a; c.b = b; c.inst = op;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((idx0 < q0.size() || idx1 < q1.size() || m_out[0] || m_out[1] || m_av) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      compared++; mismatched++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  // Requester and ALU drivers: apply inputs 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (hs0) idx0++;
    if (hs1) idx1++;
    i_req0_valid = idx0 < q0.size();
    if (i_req0_valid) {i_req0_data_a, i_req0_data_b, i_req0_inst} = q0[idx0];
    i_req1_valid = idx1 < q1.size();
    if (i_req1_valid) {i_req1_data_a, i_req1_data_b, i_req1_inst} = q1[idx1];
    i_alu_valid = (alu_pend && alu_en) || (spur_set != spur_used);
    i_alu_data  = alu_res;
    spur_used   = spur_set;
  end

  // Reference model and per-cycle comparison, evaluated mid-cycle.
  always @(negedge clk) begin
    bit e0, e1, g0, g1;
    int n;
    cyc++;
    hs0 = i_req0_valid && o_req0_ready;
    hs1 = i_req1_valid && o_req1_ready;
    alu_pend = o_alu_valid;
    alu_res  = alu_f(o_alu_data_a, o_alu_data_b, o_alu_inst);
    e0 = !rst && i_req0_valid && !m_out[0] && !m_av;
    e1 = !rst && i_req1_valid && !m_out[1] && !m_av;
    g0 = e0 && (!e1 || m_last == 1);
    g1 = e1 && (!e0 || m_last == 0);
    if (started) begin
      check("req_ready", {o_req1_ready, o_req0_ready}, {g1, g0});
      check("rsp0_valid", o_rsp0_valid, !rst && m_have[0]);
      check("rsp1_valid", o_rsp1_valid, !rst && m_have[1]);
      if (!rst && m_have[0]) check("rsp0_data", o_rsp0_data, m_res[0]);
      if (!rst && m_have[1]) check("rsp1_data", o_rsp1_data, m_res[1]);
      check("alu_valid", o_alu_valid, m_av);
      check("alu_cmd", {o_alu_data_a, o_alu_data_b, o_alu_inst}, {m_aa, m_ab, m_ai});
      check("cnt0", o_cnt0, m_cnt[0]);
      check("cnt1", o_cnt1, m_cnt[1]);
      check("err", o_err, m_err);
    end
    if (rst) begin
      started = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 0; m_have[i] = 0; m_res[i] = '0; m_cnt[i] = 0;
      end
      m_err = 0; m_av = 0; m_aa = '0; m_ab = '0; m_ai = '0; m_atag = 0; m_last = 1;
      m_wq.delete();
    end else if (started) begin
      if (m_have[0] && i_rsp0_ready) begin
        m_have[0] = 0; m_out[0] = 0;
        if (m_cnt[0] < CMAX) m_cnt[0]++;
      end
      if (m_have[1] && i_rsp1_ready) begin
        m_have[1] = 0; m_out[1] = 0;
        if (m_cnt[1] < CMAX) m_cnt[1]++;
      end
      if (i_alu_valid) begin
        if (m_wq.size() > 0) begin
          n = m_wq.pop_front();
          m_have[n] = 1; m_res[n] = i_alu_data;
        end else begin
          m_err = 1;
        end
      end
      if (m_av) m_wq.push_back(m_atag);
      if (g0 || g1) begin
        n = g1 ? 1 : 0;
        m_out[n] = 1; m_av = 1; m_last = n; m_atag = n;
        if (g1) {m_aa, m_ab, m_ai} = {i_req1_data_a, i_req1_data_b, i_req1_inst};
        else    {m_aa, m_ab, m_ai} = {i_req0_data_a, i_req0_data_b, i_req0_inst};
      end else begin
        m_av = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int hs1_cyc[$];
    bit stable, r0_seen;
    logic [DW-1:0] d0;

    // Reset with a request already pending: nothing may be accepted until release.
    q0.push_back(mk(8'h10, 8'h08, 3'd0));
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", {o_req1_ready, o_req0_ready}, 2'b00);
    check("rst_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
    check("rst_alu_valid", o_alu_valid, 1'b0);
    check("rst_cnt", {o_cnt1, o_cnt0}, '0);
    check("rst_err", o_err, 1'b0);
    tick(); rst = 1'b0;

    // Single op: 0x10 + 0x08 = 0x18.
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_req0_valid && o_req0_ready) break;
    end
    check("single_hs_seen", k < 20, 1'b1);
    @(negedge clk);
    check("single_alu_valid_T1", o_alu_valid, 1'b1);
    check("single_alu_cmd_T1", {o_alu_data_a, o_alu_data_b, o_alu_inst}, {8'h10, 8'h08, 3'd0});
    @(negedge clk);
    check("single_rsp_not_yet_T2", o_rsp0_valid, 1'b0);
    @(negedge clk);
    check("single_rsp_valid_T3", o_rsp0_valid, 1'b1);
    check("single_rsp_data_T3", o_rsp0_data, 8'h18);
    @(negedge clk);
    check("single_cnt0", o_cnt0, 6'd1);
    tick();
    wait_idle(50);

    // Ties after reset: requester 0 first, requester 1 once the issue stage drains, then 0 again.
    do_reset();
    tick();
    q0.push_back(mk(8'h03, 8'h04, 3'd0));
    q1.push_back(mk(8'h05, 8'h06, 3'd2));
    @(negedge clk);
    check("tie1_first", {o_req1_ready, o_req0_ready}, 2'b01);
    @(negedge clk);
    check("tie1_issue_block", {o_req1_ready, o_req0_ready}, 2'b00);
    @(negedge clk);
    check("tie1_second", {o_req1_ready, o_req0_ready}, 2'b10);
    tick();
    wait_idle(50);
    q0.push_back(mk(8'h11, 8'h22, 3'd3));
    q1.push_back(mk(8'h33, 8'h44, 3'd4));
    @(negedge clk);
    check("tie2_first", {o_req1_ready, o_req0_ready}, 2'b01);
    tick();
    wait_idle(50);

    // Back-pressure on response 0 while requester 1 streams.
    i_rsp0_ready = 1'b0;
    q0.push_back(mk(8'h21, 8'h03, 3'd1));
    q0.push_back(mk(8'h07, 8'h09, 3'd0));
    for (int i = 0; i < 6; i++) q1.push_back(mk(8'(i * 3), 8'h01, 3'd0));
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_rsp0_valid) break;
    end
    check("bp_rsp0_seen", k < 30, 1'b1);
    d0 = o_rsp0_data;
    check("bp_rsp0_data", d0, 8'h1E);
    stable = 1'b1; r0_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!(o_rsp0_valid && o_rsp0_data == d0)) stable = 1'b0;
      if (o_req0_ready) r0_seen = 1'b1;
      if (i_req1_valid && o_req1_ready) hs1_cyc.push_back(cyc);
    end
    check("bp_rsp0_hold", stable, 1'b1);
    check("bp_req0_ready_low", r0_seen, 1'b0);
    check("bp_req1_count", hs1_cyc.size() >= 3, 1'b1);
    for (int i = 1; i < hs1_cyc.size(); i++) check("bp_req1_period", hs1_cyc[i] - hs1_cyc[i-1], 4);
    tick();
    i_rsp0_ready = 1'b1;
    wait_idle(100);

    // Every opcode value on both requesters, simultaneous response acceptance included.
    for (int i = 0; i < 8; i++) begin
      q1.push_back(mk(8'(8'h5A + i), 8'h33, 3'(i)));
      q0.push_back(mk(8'(i * 17), 8'hF0, 3'(7 - i)));
    end
    wait_idle(200);

    // Counter saturation on requester 1.
    for (int i = 0; i < CMAX + 3; i++) q1.push_back(mk(8'(i), 8'(i + 1), 3'd0));
    wait_idle(1000);
    @(negedge clk);
    check("sat_cnt1", o_cnt1, 6'h3F);

    // Reset while slot 0 waits on the ALU; the late result lands as a spurious return.
    tick();
    alu_en = 1'b0;
    q0.push_back(mk(8'h01, 8'h02, 3'd0));
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_req0_valid && o_req0_ready) break;
    end
    check("midrst_hs_seen", k < 20, 1'b1);
    tick();
    tick(); rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", {o_req1_ready, o_req0_ready}, 2'b00);
    check("midrst_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
    tick(); rst = 1'b0; spur_set++;
    @(negedge clk);
    check("midrst_alu_valid", o_alu_valid, 1'b0);
    check("midrst_alu_cmd", {o_alu_data_a, o_alu_data_b, o_alu_inst}, '0);
    check("midrst_cnt", {o_cnt1, o_cnt0}, '0);
    check("midrst_err_before", o_err, 1'b0);
    tick();
    @(negedge clk);
    check("midrst_err_after", o_err, 1'b1);
    check("midrst_no_rsp0", o_rsp0_valid, 1'b0);
    tick();
    alu_en = 1'b1;

    // Spurious ALU return with both slots free; error stays set through later traffic.
    do_reset();
    tick(); spur_set++;
    @(negedge clk);
    check("spur_err_before", o_err, 1'b0);
    tick();
    @(negedge clk);
    check("spur_err_set", o_err, 1'b1);
    check("spur_cnt", {o_cnt1, o_cnt0}, '0);
    check("spur_no_rsp", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
    tick();
    q0.push_back(mk(8'h40, 8'h02, 3'd6));
    wait_idle(50);
    @(negedge clk);
    check("spur_err_sticky", o_err, 1'b1);
    check("spur_cnt0_after_op", o_cnt0, 6'd1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
